conv_accumulator_27x16: RTL and testbench
=========================================

CONV_ACCUMULATOR_27X16 -- requirements
Module: conv_accumulator_27X16

Interface
REQ-001 SHALL have parameter bitsize, default 14, giving the width of one product, bias and result element.
REQ-002 SHALL have parameter FRAC_BITS, default 7, giving the fractional bits shared by products, bias and result.
REQ-003 SHALL have parameter MAX_TILES, default 16, giving the maximum number of accumulated beats per output.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port start_flag, input, 1 bit: begins a new output pixel and clears the accumulators.
REQ-007 SHALL have port Mult_result, input, bitsize*27*16 bits: 16 channels of 27 signed products, channel i at [i*27*bitsize +: 27*bitsize].
REQ-008 SHALL have port mult_valid, input, 1 bit: Mult_result holds a valid beat.
REQ-009 SHALL have port last_tile, input, 1 bit: qualified by mult_valid, marks the final beat of the pixel.
REQ-010 SHALL have port bias, input, bitsize*16 bits: per-channel signed bias, sampled on the last_tile beat.
REQ-011 SHALL have port conv_result, output, bitsize*16 bits: per-channel saturated result.
REQ-012 SHALL have port valid, output, 1 bit: conv_result is valid; pulses high for one cycle.
REQ-013 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-014 SHALL have port overflow, output, 1 bit: sticky flag set when the beat count exceeds MAX_TILES.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM, FLUSH and OUT.
REQ-016 IDLE: SHALL go to ACCUM on start_flag; mult_valid is ignored in IDLE.
REQ-017 ACCUM: SHALL accept one beat per cycle whenever mult_valid is high; a beat with last_tile high SHALL move the FSM to FLUSH.
REQ-018 FLUSH: SHALL ignore mult_valid and SHALL move to OUT in the cycle the tagged last beat leaves the accumulate stage.
REQ-019 OUT: SHALL assert valid for exactly one cycle, then return to IDLE.
REQ-020 SHALL sign-extend each product to ACC_W = bitsize+5+clog2(MAX_TILES) bits, with no rounding or shift (all operands share the Q(FRAC_BITS) format).
REQ-021 SHALL reduce the 27 products per channel through a 5-level adder tree with a register after every level.
REQ-022 SHALL add the tree sum to the channel accumulator in stage 6; the accumulator is cleared by start_flag.
REQ-023 SHALL compute acc + sign-extended bias in stage 7 and clip the result to [-2^(bitsize-1), 2^(bitsize-1)-1].
REQ-024 SHALL assert valid exactly 7 cycles after the last_tile beat.
REQ-025 SHALL hold conv_result until the next valid pulse or reset.
REQ-026 SHALL accept back-to-back beats with no bubble.
REQ-027 A start_flag in ACCUM, FLUSH or OUT SHALL abort the pixel: kill in-flight beats, clear the accumulators, enter ACCUM, and suppress valid for the aborted pixel.
REQ-028 SHALL stop counting after the (MAX_TILES+1)-th beat of a pixel, set overflow, and keep accumulating without wrap; overflow is cleared only by rst or start_flag.
REQ-029 A single beat carrying both start_flag and mult_valid SHALL be accepted as the first beat of the new pixel.

Reset
REQ-030 While rst is high, the FSM SHALL be in IDLE and all pipeline valid bits, accumulators, conv_result, valid, busy and overflow SHALL be 0.
REQ-031 Reset SHALL take priority over start_flag and mult_valid, including mid-pixel; no valid SHALL follow a reset for a pixel begun before it.

Structure
REQ-032 A shared package cnn_pkg SHALL hold ACC_W, the tree depth (5), the pipeline latency (7) and the FSM state encodings.
REQ-033 SHALL contain one sub-module, adder_tree_27, which is the pipelined 27-input reducer instantiated 16 times.
REQ-034 The FSM, beat counter and saturation logic SHALL reside in the top module.

Verification
REQ-035 One tile, every product 128 (1.0), bias 0: SHALL give all 16 channels 3456, with valid 7 cycles after the beat.
REQ-036 Three back-to-back tiles, every product 10, bias 5, last_tile on beat 3: SHALL give 815 per channel and exactly one valid pulse.
REQ-037 Saturation, one tile: products 8191 SHALL give 8191; products -8192 SHALL give -8192.
REQ-038 rst asserted in FLUSH: SHALL give no valid, conv_result 0 and busy 0 on the next cycle.
REQ-039 start_flag during ACCUM after 2 beats, then 1 tile of products 1 with bias 0: SHALL give 27 with no stale contribution.
REQ-040 17 beats with MAX_TILES=16: SHALL set overflow and still deliver valid on the last_tile beat.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared sizing constants and FSM encoding for the 27x16 convolution accumulator.
package cnn_pkg;

  localparam int unsigned NumProducts = 27;
  localparam int unsigned NumChannels = 16;
  localparam int unsigned TreeDepth   = 5;
  localparam int unsigned PipeLatency = 7;

  // 27 products need 5 guard bits, then log2 of the beat count on top.
  function automatic int unsigned acc_w(input int unsigned elem_w, input int unsigned max_tiles);
    return elem_w + 5 + $clog2(max_tiles);
  endfunction

  localparam int unsigned ACC_W = acc_w(14, 16);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StFlush = 2'd2,
    StOut   = 2'd3
  } state_e;

endpackage

// File: rtl/adder_tree_27.sv
// Pipelined 27-input signed reducer: five adder levels, each followed by a register.
module adder_tree_27
  import cnn_pkg::*;
#(
  parameter int unsigned InW  = 14,
  parameter int unsigned OutW = ACC_W
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NumProducts*InW-1:0] prod_i,
  output logic signed [OutW-1:0]     sum_o
);

  typedef logic signed [OutW-1:0] sum_t;

  sum_t ext [NumProducts];
  sum_t l1_d [14];
  sum_t l1_q [14];
  sum_t l2_d [7];
  sum_t l2_q [7];
  sum_t l3_d [4];
  sum_t l3_q [4];
  sum_t l4_d [2];
  sum_t l4_q [2];
  sum_t l5_d;
  sum_t l5_q;

  // Odd leftovers at levels 1 and 3 pass straight through to keep all paths 5 deep.
  always_comb begin
    for (int i = 0; i < NumProducts; i++) begin
      ext[i] = {{(OutW-InW){prod_i[i*InW+InW-1]}}, prod_i[i*InW +: InW]};
    end
    for (int i = 0; i < 13; i++) begin
      l1_d[i] = ext[2*i] + ext[2*i+1];
    end
    l1_d[13] = ext[26];
    for (int i = 0; i < 7; i++) begin
      l2_d[i] = l1_q[2*i] + l1_q[2*i+1];
    end
    for (int i = 0; i < 3; i++) begin
      l3_d[i] = l2_q[2*i] + l2_q[2*i+1];
    end
    l3_d[3] = l2_q[6];
    for (int i = 0; i < 2; i++) begin
      l4_d[i] = l3_q[2*i] + l3_q[2*i+1];
    end
    l5_d = l4_q[0] + l4_q[1];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      l1_q <= '{default: '0};
      l2_q <= '{default: '0};
      l3_q <= '{default: '0};
      l4_q <= '{default: '0};
      l5_q <= '0;
    end else begin
      l1_q <= l1_d;
      l2_q <= l2_d;
      l3_q <= l3_d;
      l4_q <= l4_d;
      l5_q <= l5_d;
    end
  end

  assign sum_o = l5_q;

endmodule

// File: rtl/conv_accumulator_27x16.sv
// Accumulates 16 channels of 27 products over several beats, adds bias and saturates.
module conv_accumulator_27x16
  import cnn_pkg::*;
#(
  parameter int unsigned bitsize   = 14,
  parameter int unsigned FRAC_BITS = 7,
  parameter int unsigned MAX_TILES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_flag,
  input  logic [bitsize*27*16-1:0]  Mult_result,
  input  logic                      mult_valid,
  input  logic                      last_tile,
  input  logic [bitsize*16-1:0]     bias,
  output logic [bitsize*16-1:0]     conv_result,
  output logic                      valid,
  output logic                      busy,
  output logic                      overflow
);

  localparam int unsigned AccW = acc_w(bitsize, MAX_TILES);
  localparam int unsigned CntW = $clog2(MAX_TILES + 2);
  localparam logic signed [AccW:0] SatMax =
    $signed({{(AccW+2-bitsize){1'b0}}, {(bitsize-1){1'b1}}});
  localparam logic signed [AccW:0] SatMin =
    $signed({{(AccW+2-bitsize){1'b1}}, {(bitsize-1){1'b0}}});

  if (FRAC_BITS >= bitsize || PipeLatency != TreeDepth + 2) begin : g_bad_params
    $error("conv_accumulator_27x16: unsupported parameter combination");
  end

  typedef logic signed [AccW-1:0] acc_t;

  state_e                   state_q, state_d;
  logic [TreeDepth-1:0]     vld_q, vld_d;
  logic [TreeDepth-1:0]     last_q, last_d;
  logic [CntW-1:0]          cnt_q, cnt_d;
  logic                     ovf_q, ovf_d;
  logic [bitsize*16-1:0]    bias_q, bias_d;
  logic [bitsize*16-1:0]    res_q, res_d;
  logic                     out_vld_q, out_vld_d;
  acc_t                     acc_q [NumChannels];
  acc_t                     acc_d [NumChannels];
  acc_t                     tree_sum [NumChannels];
  logic [bitsize*16-1:0]    sat_res;
  logic signed [AccW:0]     biased;
  logic                     accept;

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    adder_tree_27 #(
      .InW  (bitsize),
      .OutW (AccW)
    ) u_tree (
      .clk_i  (clk),
      .rst_i  (rst),
      .prod_i (Mult_result[c*NumProducts*bitsize +: NumProducts*bitsize]),
      .sum_o  (tree_sum[c])
    );
  end

  // A beat paired with start_flag opens the new pixel regardless of state.
  assign accept = mult_valid & (start_flag | (state_q == StAccum));

  always_comb begin
    state_d   = state_q;
    vld_d     = {vld_q[TreeDepth-2:0], accept};
    last_d    = {last_q[TreeDepth-2:0], accept & last_tile};
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    bias_d    = bias_q;
    res_d     = res_q;
    out_vld_d = 1'b0;
    if (accept && last_tile) begin
      bias_d = bias;
    end
    if (start_flag) begin
      vld_d   = {{(TreeDepth-1){1'b0}}, accept};
      last_d  = {{(TreeDepth-1){1'b0}}, accept & last_tile};
      cnt_d   = {{(CntW-1){1'b0}}, accept};
      ovf_d   = 1'b0;
      state_d = (accept && last_tile) ? StFlush : StAccum;
    end else begin
      // Counter saturates at MAX_TILES+1; the flag stays until the next pixel.
      if (accept) begin
        if (cnt_q <= CntW'(MAX_TILES)) cnt_d = cnt_q + 1'b1;
        if (cnt_q >= CntW'(MAX_TILES)) ovf_d = 1'b1;
      end
      unique case (state_q)
        StIdle:  ;
        StAccum: if (accept && last_tile) state_d = StFlush;
        StFlush: if (vld_q[TreeDepth-1] && last_q[TreeDepth-1]) state_d = StOut;
        StOut: begin
          state_d   = StIdle;
          out_vld_d = 1'b1;
          res_d     = sat_res;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    for (int c = 0; c < NumChannels; c++) begin
      if (start_flag) begin
        acc_d[c] = '0;
      end else if (vld_q[TreeDepth-1]) begin
        acc_d[c] = acc_q[c] + tree_sum[c];
      end else begin
        acc_d[c] = acc_q[c];
      end
    end
  end

  always_comb begin
    sat_res = '0;
    biased  = '0;
    for (int c = 0; c < NumChannels; c++) begin
      biased = {acc_q[c][AccW-1], acc_q[c]} +
               {{(AccW+1-bitsize){bias_q[c*bitsize+bitsize-1]}}, bias_q[c*bitsize +: bitsize]};
      if (biased > SatMax) begin
        sat_res[c*bitsize +: bitsize] = SatMax[bitsize-1:0];
      end else if (biased < SatMin) begin
        sat_res[c*bitsize +: bitsize] = SatMin[bitsize-1:0];
      end else begin
        sat_res[c*bitsize +: bitsize] = biased[bitsize-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      vld_q     <= '0;
      last_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      bias_q    <= '0;
      res_q     <= '0;
      out_vld_q <= 1'b0;
      acc_q     <= '{default: '0};
    end else begin
      state_q   <= state_d;
      vld_q     <= vld_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      bias_q    <= bias_d;
      res_q     <= res_d;
      out_vld_q <= out_vld_d;
      acc_q     <= acc_d;
    end
  end

  assign conv_result = res_q;
  assign valid       = out_vld_q;
  assign busy        = (state_q != StIdle);
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_conv_accumulator_27x16.sv
// Self-checking bench: directed vector table, corner-case sequences and randomized pixels.
module tb_conv_accumulator_27x16;

  localparam int BW  = 14;
  localparam int NP  = 27;
  localparam int NC  = 16;
  localparam int LIM = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start_flag;
  logic                 mult_valid;
  logic                 last_tile;
  logic [BW*NP*NC-1:0]  Mult_result;
  logic [BW*NC-1:0]     bias;
  logic [BW*NC-1:0]     conv_result;
  logic                 valid;
  logic                 busy;
  logic                 overflow;

  int checks = 0;
  int errors = 0;
  int model_sum [NC];
  int bias_m [NC];
  int exp_res [NC];

  typedef struct {
    string name;
    int    nbeats;
    int    prod;
    int    bias_v;
    int    expect_v;
  } vec_t;

  vec_t vecs [6];

  always #5 clk = ~clk;

  conv_accumulator_27x16 dut (
    .clk         (clk),
    .rst         (rst),
    .start_flag  (start_flag),
    .Mult_result (Mult_result),
    .mult_valid  (mult_valid),
    .last_tile   (last_tile),
    .bias        (bias),
    .conv_result (conv_result),
    .valid       (valid),
    .busy        (busy),
    .overflow    (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int clip(input int v);
    if (v > 8191) return 8191;
    if (v < -8192) return -8192;
    return v;
  endfunction

  function automatic int ch_res(input int c);
    return int'($signed(conv_result[c*BW +: BW]));
  endfunction

  task automatic clear_in();
    start_flag = 1'b0;
    mult_valid = 1'b0;
    last_tile  = 1'b0;
  endtask

  task automatic set_bias_all(input int b);
    for (int c = 0; c < NC; c++) begin
      bias[c*BW +: BW] = BW'(b);
      bias_m[c] = b;
    end
  endtask

  task automatic beat_const(input int v, input bit last);
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++)
        Mult_result[(c*NP+p)*BW +: BW] = BW'(v);
    mult_valid = 1'b1;
    last_tile  = last;
  endtask

  task automatic beat_rand(input int m, input bit last);
    int v;
    for (int c = 0; c < NC; c++)
      for (int p = 0; p < NP; p++) begin
        v = int'($urandom_range(0, 2*m)) - m;
        Mult_result[(c*NP+p)*BW +: BW] = BW'(v);
        model_sum[c] += v;
      end
    mult_valid = 1'b1;
    last_tile  = last;
  endtask

  task automatic set_exp_all(input int v);
    for (int c = 0; c < NC; c++) exp_res[c] = v;
  endtask

  // The last beat is already on the inputs; lat0 counts cycles already spent since it.
  task automatic await_result(input string name, input int lat0);
    int lat;
    int extra;
    lat = lat0;
    tick();
    lat++;
    clear_in();
    while (!valid && lat < LIM) begin
      tick();
      lat++;
    end
    chk({name, "_latency"}, lat, 7);
    for (int c = 0; c < NC; c++) chk($sformatf("%s_ch%0d", name, c), ch_res(c), exp_res[c]);
    extra = 0;
    repeat (3) begin
      tick();
      if (valid) extra++;
    end
    chk({name, "_extra_pulses"}, extra, 0);
    chk({name, "_hold"}, ch_res(NC-1), exp_res[NC-1]);
    chk({name, "_busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int extra;
    vecs[0] = '{"one_tile_unity", 1, 128, 0, 3456};
    vecs[1] = '{"three_tiles", 3, 10, 5, 815};
    vecs[2] = '{"sat_pos", 1, 8191, 0, 8191};
    vecs[3] = '{"sat_neg", 1, -8192, 0, -8192};
    vecs[4] = '{"neg_bias", 2, -3, -100, -262};
    vecs[5] = '{"bias_sat", 1, 300, 8000, 8191};

    rst = 1'b1;
    clear_in();
    Mult_result = '0;
    set_bias_all(0);
    tick();
    start_flag = 1'b1;
    beat_const(7, 1'b1);
    tick();
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_result_nonzero", int'(|conv_result), 0);
    clear_in();
    rst = 1'b0;
    tick();

    foreach (vecs[i]) begin
      set_bias_all(vecs[i].bias_v);
      start_flag = 1'b1;
      tick();
      start_flag = 1'b0;
      chk({vecs[i].name, "_busy"}, int'(busy), 1);
      for (int b = 0; b < vecs[i].nbeats; b++) begin
        beat_const(vecs[i].prod, b == vecs[i].nbeats - 1);
        if (b != vecs[i].nbeats - 1) tick();
      end
      set_exp_all(vecs[i].expect_v);
      await_result(vecs[i].name, 0);
    end

    // Beats offered while idle must not leak into the next pixel.
    set_bias_all(0);
    beat_const(99, 1'b1);
    tick();
    tick();
    chk("idle_ignore_busy", int'(busy), 0);
    clear_in();
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    beat_const(1, 1'b1);
    set_exp_all(27);
    await_result("idle_ignore", 0);

    set_bias_all(3);
    start_flag = 1'b1;
    beat_const(2, 1'b1);
    set_exp_all(57);
    await_result("start_with_beat", 0);

    set_bias_all(0);
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    beat_const(100, 1'b0);
    tick();
    beat_const(100, 1'b0);
    tick();
    clear_in();
    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    beat_const(1, 1'b1);
    set_exp_all(27);
    await_result("abort_accum", 0);

    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    beat_const(100, 1'b1);
    tick();
    clear_in();
    tick();
    start_flag = 1'b1;
    beat_const(1, 1'b1);
    set_exp_all(27);
    await_result("abort_flush", 0);

    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    beat_const(1, 1'b1);
    tick();
    beat_const(500, 1'b1);
    set_exp_all(27);
    await_result("flush_ignore", 1);

    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    beat_const(50, 1'b1);
    tick();
    clear_in();
    tick();
    tick();
    chk("rst_flush_busy_before", int'(busy), 1);
    rst = 1'b1;
    tick();
    chk("rst_flush_valid", int'(valid), 0);
    chk("rst_flush_result_nonzero", int'(|conv_result), 0);
    chk("rst_flush_busy", int'(busy), 0);
    rst = 1'b0;
    extra = 0;
    repeat (10) begin
      tick();
      if (valid) extra++;
    end
    chk("rst_flush_late_valid", extra, 0);

    start_flag = 1'b1;
    tick();
    start_flag = 1'b0;
    for (int b = 0; b < 17; b++) begin
      beat_const(1, b == 16);
      if (b < 16) tick();
      if (b == 15) chk("ovf_after_16", int'(overflow), 0);
    end
    set_exp_all(459);
    await_result("ovf_17_beats", 0);
    chk("ovf_sticky", int'(overflow), 1);
    start_flag = 1'b1;
    tick();
    clear_in();
    chk("ovf_cleared_by_start", int'(overflow), 0);

    for (int k = 0; k < 40; k++) begin
      int nb;
      int m;
      int mb;
      bit sb;
      nb = int'($urandom_range(1, 5));
      m  = ($urandom_range(0, 3) == 0) ? 8191 : 250;
      mb = ($urandom_range(0, 1) == 0) ? 8191 : 300;
      sb = ($urandom_range(0, 3) == 0);
      for (int c = 0; c < NC; c++) begin
        model_sum[c] = 0;
        bias_m[c] = int'($urandom_range(0, 2*mb)) - mb;
        bias[c*BW +: BW] = BW'(bias_m[c]);
      end
      start_flag = 1'b1;
      if (sb) beat_rand(m, nb == 1);
      if (!(sb && nb == 1)) begin
        tick();
        clear_in();
        for (int b = (sb ? 1 : 0); b < nb; b++) begin
          if ($urandom_range(0, 3) == 0) tick();
          beat_rand(m, b == nb - 1);
          if (b != nb - 1) begin
            tick();
            clear_in();
          end
        end
      end
      for (int c = 0; c < NC; c++) exp_res[c] = clip(model_sum[c] + bias_m[c]);
      await_result($sformatf("rnd%0d", k), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
